// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//   Reset manager for the FPGA top level. It holds the system in reset for a
//   stretch period after power-on or any later reset trigger, then releases
//   N_RST reset domains one after another, STAGGER cycles apart. The following
//   triggers restart the sequence:
//     - a debounced pushbutton (level trigger: holding it keeps reset asserted)
//     - a software reset request (rising edge)
//     - a CPU trap (rising edge, only when built with TRAP_RST_EN)
//   The cause of the most recent reset is kept in rst_cause.
//
//   Optional feature macro: TRAP_RST_EN
//     defined   : a rising edge on trap triggers a reset and sets rst_cause[3]
//     undefined : trap is ignored, its edge logic is not built, rst_cause[3]=0
//
// Ports
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low board reset (power-on)
//   btn_rst     in   1      raw pushbutton, asynchronous to clk, active-high
//   sw_rst_req  in   1      software reset request, synchronous, edge-triggered
//   trap        in   1      CPU trap, synchronous, edge-triggered
//   rst_out     out  N_RST  active-high resets, bit 0 released first
//   rst_done    out  1      high once every rst_out bit is released
//   rst_cause   out  4      {trap, sw, btn, por} cause(s) of the last reset
// -----------------------------------------------------------------------------
module rst_sequencer #(
  parameter int unsigned          N_RST     = 2,
  parameter int unsigned          STRETCH_W = 16,
  parameter logic [STRETCH_W-1:0] STRETCH   = 16'hFFFF,
  parameter int unsigned          STAGGER   = 16,
  parameter int unsigned          DEB_W     = 16,
  parameter logic [DEB_W-1:0]     DEB       = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_rst,
  input  logic             sw_rst_req,
  input  logic             trap,
  output logic [N_RST-1:0] rst_out,
  output logic             rst_done,
  output logic [3:0]       rst_cause
);

  // The stagger counter is reloaded with STAGGER-1 so that consecutive
  // releases are exactly STAGGER edges apart (the zero cycle is the release).
  localparam logic [STRETCH_W-1:0] STAGGER_RELOAD = STRETCH_W'(STAGGER - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button path: two-flop synchroniser followed by a saturating debounce
  // counter. The counter restarts on any low sample, so a bounce restarts the
  // debounce window.
  // ---------------------------------------------------------------------------
  logic             btn_meta;
  logic             btn_sync;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_rst;
      btn_sync <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
    end else if (!btn_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB) begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Level trigger: stays high as long as the button stays pressed, which keeps
  // reloading the stretch counter.
  assign btn_deb = (deb_cnt == DEB);

  // ---------------------------------------------------------------------------
  // Software request: one-cycle pulse on the rising edge only, so a request
  // held high for many cycles triggers a single reset.
  // ---------------------------------------------------------------------------
  logic sw_d;
  logic sw_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_d <= 1'b0;
    end else begin
      sw_d <= sw_rst_req;
    end
  end

  assign sw_edge = sw_rst_req & ~sw_d;

  // ---------------------------------------------------------------------------
  // Trap request, same rising-edge detection as the software request.
  // ---------------------------------------------------------------------------
  logic trap_edge;

`ifdef TRAP_RST_EN
  logic trap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_d <= 1'b0;
    end else begin
      trap_d <= trap;
    end
  end

  assign trap_edge = trap & ~trap_d;
`else
  logic unused_trap;

  assign unused_trap = trap;
  assign trap_edge   = 1'b0;
`endif

  // Cause bit layout is {trap, sw, btn, por}; por never comes from a trigger.
  logic [3:0] trig_bits;
  logic       trig;

  assign trig_bits = {trap_edge, sw_edge, btn_deb, 1'b0};
  assign trig      = |trig_bits;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t                state_q;
  state_t                state_d;
  logic [STRETCH_W-1:0]  cnt_q;
  logic [STRETCH_W-1:0]  cnt_d;
  logic [N_RST-1:0]      out_q;
  logic [N_RST-1:0]      out_d;
  logic                  done_q;
  logic                  done_d;
  logic [3:0]            cause_q;
  logic [3:0]            cause_d;
  logic [N_RST-1:0]      out_released;

  // Outputs are released strictly from bit 0 upward, so the still-asserted
  // bits always form a contiguous block at the top. Clearing the lowest set
  // bit therefore releases the next domain without needing a separate index.
  assign out_released = out_q & (out_q - N_RST'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= STRETCH;
      out_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= 4'b0001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic. A trigger always wins over counting or releasing.
  // Inside ASSERT, new causes accumulate; once the sequence has started
  // releasing (or is running), a trigger restarts it and replaces the cause.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;
    cause_d = cause_q;

    unique case (state_q)
      ST_ASSERT: begin
        out_d  = '1;
        done_d = 1'b0;
        if (trig) begin
          cnt_d   = STRETCH;
          cause_d = cause_q | trig_bits;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - STRETCH_W'(1);
        end else begin
          out_d = out_released;
          cnt_d = STAGGER_RELOAD;
          // With a single output the first release is also the last one.
          if (out_released == '0) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (trig) begin
          state_d = ST_ASSERT;
          cnt_d   = STRETCH;
          out_d   = '1;
          done_d  = 1'b0;
          cause_d = trig_bits;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - STRETCH_W'(1);
        end else begin
          out_d = out_released;
          cnt_d = STAGGER_RELOAD;
          if (out_released == '0) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (trig) begin
          state_d = ST_ASSERT;
          cnt_d   = STRETCH;
          out_d   = '1;
          done_d  = 1'b0;
          cause_d = trig_bits;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = STRETCH;
        out_d   = '1;
        done_d  = 1'b0;
      end
    endcase
  end

  assign rst_out   = out_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
//   Bench for rst_sequencer with STRETCH=8, STAGGER=4, N_RST=3, DEB=4.
//   The reference model tracks the number of clock edges since the latest
//   reset event and derives every output from that elapsed time:
//     rst_out[i] is released once elapsed >= STRETCH+1+i*STAGGER
//   Button debounce is modelled as a count of consecutive high button samples,
//   seen through the synchroniser delay.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

  localparam int N       = 3;
  localparam int STRETCH = 8;
  localparam int STAGGER = 4;
  localparam int DEB     = 4;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         btn_rst    = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic         trap       = 1'b0;
  logic [N-1:0] rst_out;
  logic         rst_done;
  logic [3:0]   rst_cause;

  int checks = 0;
  int errors = 0;

  rst_sequencer #(
    .N_RST     (N),
    .STRETCH_W (16),
    .STRETCH   (16'd8),
    .STAGGER   (STAGGER),
    .DEB_W     (16),
    .DEB       (16'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_rst    (btn_rst),
    .sw_rst_req (sw_rst_req),
    .trap       (trap),
    .rst_out    (rst_out),
    .rst_done   (rst_done),
    .rst_cause  (rst_cause)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int           m_elapsed = 0;
  int           run_h [3] = '{0, 0, 0};
  logic         sw_prev   = 1'b0;
`ifdef TRAP_RST_EN
  logic         trap_prev = 1'b0;
`endif
  logic [N-1:0] exp_out   = '1;
  logic         exp_done  = 1'b0;
  logic [3:0]   exp_cause = 4'b0001;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] bits;
    int         new_run;
    if (!rst_n) begin
      m_elapsed = 0;
      exp_cause = 4'b0001;
      run_h     = '{0, 0, 0};
      sw_prev   = 1'b0;
`ifdef TRAP_RST_EN
      trap_prev = 1'b0;
`endif
    end else begin
      bits = 4'b0000;
      // run_h[2] is the high-run length ending three edges ago: two edges of
      // synchroniser plus one edge for the debounce counter to update.
      if (run_h[2] >= DEB) bits[1] = 1'b1;
      if (sw_rst_req && !sw_prev) bits[2] = 1'b1;
`ifdef TRAP_RST_EN
      if (trap && !trap_prev) bits[3] = 1'b1;
      trap_prev = trap;
`endif
      if (bits != 4'b0000) begin
        exp_cause = (m_elapsed <= STRETCH) ? (exp_cause | bits) : bits;
        m_elapsed = 0;
      end else if (m_elapsed < 100000) begin
        m_elapsed++;
      end
      new_run  = btn_rst ? run_h[0] + 1 : 0;
      run_h[2] = run_h[1];
      run_h[1] = run_h[0];
      run_h[0] = new_run;
      sw_prev  = sw_rst_req;
    end
    for (int i = 0; i < N; i++) exp_out[i] = (m_elapsed < STRETCH + 1 + i * STAGGER);
    exp_done = (m_elapsed >= STRETCH + 1 + (N - 1) * STAGGER);
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; btn_rst = 1'b0; sw_rst_req = 1'b0; trap = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rst_out !== 3'b111 || rst_done !== 1'b0 || rst_cause !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL por_hold: out=%b done=%b cause=%b, expected 111 0 0001", rst_out, rst_done, rst_cause);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL por_seq edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 8 || n == 9 || n == 13 || n == 17) begin
        checks++;
        if (rst_out !== ((n == 8) ? 3'b111 : (n == 9) ? 3'b110 : (n == 13) ? 3'b100 : 3'b000) ||
            rst_done !== (n == 17) || rst_cause !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL por_timing edge %0d: out=%b done=%b cause=%b", n, rst_out, rst_done, rst_cause);
        end
      end
    end
  endtask

  task automatic test_btn_glitch();
    btn_rst = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL btn_glitch edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 3) btn_rst = 1'b0;
    end
    checks++;
    if (rst_done !== 1'b1 || rst_out !== 3'b000) begin
      errors++;
      $display("[TB] FAIL btn_glitch_run: out=%b done=%b, expected 000 1", rst_out, rst_done);
    end
  endtask

  task automatic test_btn_reset();
    btn_rst = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL btn_reset edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 6) begin
        checks++;
        if (rst_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL btn_early: done=%b, expected 1", rst_done);
        end
      end
      if (n == 7) begin
        checks++;
        if (rst_out !== 3'b111 || rst_cause !== 4'b0010) begin
          errors++;
          $display("[TB] FAIL btn_trigger: out=%b cause=%b, expected 111 0010", rst_out, rst_cause);
        end
      end
      if (n == 8) btn_rst = 1'b0;
    end
    checks++;
    if (rst_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL btn_recover: done=%b, expected 1", rst_done);
    end
  endtask

  task automatic test_simultaneous();
    btn_rst = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL simul edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 7) begin
        checks++;
        if (rst_out !== 3'b111 || rst_cause !== 4'b0110) begin
          errors++;
          $display("[TB] FAIL simul_cause: out=%b cause=%b, expected 111 0110", rst_out, rst_cause);
        end
      end
      if (n == 6) sw_rst_req = 1'b1;
      if (n == 8) btn_rst = 1'b0;
      if (n == 26) sw_rst_req = 1'b0;
    end
    checks++;
    if (rst_done !== 1'b1 || rst_cause !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL sw_held_once: done=%b cause=%b, expected 1 0110", rst_done, rst_cause);
    end
  endtask

  task automatic test_sw_in_release();
    int r = 0;
    sw_rst_req = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL sw_release edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 1) sw_rst_req = 1'b0;
      if (r == 0 && rst_out === 3'b110) r = n;
      if (r != 0 && n == r + 1) sw_rst_req = 1'b1;
      if (r != 0 && n == r + 2) begin
        sw_rst_req = 1'b0;
        checks++;
        if (rst_out !== 3'b111 || rst_cause !== 4'b0100) begin
          errors++;
          $display("[TB] FAIL sw_restart: out=%b cause=%b, expected 111 0100", rst_out, rst_cause);
        end
      end
      if (r != 0 && (n == r + 10 || n == r + 11)) begin
        checks++;
        if (rst_out !== ((n == r + 10) ? 3'b111 : 3'b110)) begin
          errors++;
          $display("[TB] FAIL sw_rerelease edge %0d: out=%b", n, rst_out);
        end
      end
    end
    checks++;
    if (r == 0 || rst_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sw_release_timeout: release edge=%0d done=%b, expected edge 10 and done 1", r, rst_done);
    end
  endtask

  task automatic test_trap();
    trap = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL trap edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 1) begin
        trap = 1'b0;
        checks++;
`ifdef TRAP_RST_EN
        if (rst_out !== 3'b111 || rst_cause !== 4'b1000) begin
          errors++;
          $display("[TB] FAIL trap_reset: out=%b cause=%b, expected 111 1000", rst_out, rst_cause);
        end
`else
        if (rst_out !== 3'b000 || rst_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL trap_ignored: out=%b done=%b, expected 000 1", rst_out, rst_done);
        end
`endif
      end
    end
  endtask

  task automatic test_por_mid_release();
    int r = 0;
    sw_rst_req = 1'b1;
    for (int n = 1; n <= 20 && r == 0; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL por_mid_pre edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      sw_rst_req = 1'b0;
      if (rst_out === 3'b110) r = n;
    end
    checks++;
    if (r == 0) begin
      errors++;
      $display("[TB] FAIL por_mid_timeout: out=%b, expected 110 within 20 edges", rst_out);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rst_out !== 3'b111 || rst_done !== 1'b0 || rst_cause !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL por_async: out=%b done=%b cause=%b, expected 111 0 0001", rst_out, rst_done, rst_cause);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL por_mid_seq edge %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n == 9 || n == 17) begin
        checks++;
        if (rst_out !== ((n == 9) ? 3'b110 : 3'b000) || rst_done !== (n == 17)) begin
          errors++;
          $display("[TB] FAIL por_mid_timing edge %0d: out=%b done=%b", n, rst_out, rst_done);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int n = 1; n <= 840; n++) begin
      @(negedge clk);
      checks++;
      if (rst_out !== exp_out || rst_done !== exp_done || rst_cause !== exp_cause) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: out=%b done=%b cause=%b, expected %b %b %b", n, rst_out, rst_done, rst_cause, exp_out, exp_done, exp_cause);
      end
      if (n <= 800) begin
        if (hold == 0) begin
          btn_rst = ($urandom % 3 == 0);
          hold    = $urandom_range(1, 12);
        end
        hold--;
        sw_rst_req = ($urandom % 20 == 0);
        trap       = ($urandom % 25 == 0);
      end else begin
        btn_rst = 1'b0; sw_rst_req = 1'b0; trap = 1'b0;
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_btn_glitch();
    test_btn_reset();
    test_simultaneous();
    test_sw_in_release();
    test_trap();
    test_por_mid_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
